// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, LSB-first assembly and a
// valid/ready holding register carrying framing-error and overrun pulses.
module uart_rx #(
    parameter int CLOCK_HZ     = 1_000_000,
    parameter int BAUD_HZ      = 9_600,
    parameter int CLKS_PER_BIT = CLOCK_HZ / BAUD_HZ,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    state_t state, next_state;
    logic [1:0] sync;
    logic rx_s;
    logic [CW-1:0] cnt, next_cnt;
    logic [2:0] idx, next_idx;
    logic [7:0] shift, next_shift;
    logic half_end, bit_end, done, bad_stop, load;
    assign rx_s = sync[1];
    assign half_end = cnt == CW'(HALF_BIT - 1);
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            sync  <= 2'b11;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            sync  <= {sync[0], serial_rx};
            cnt   <= next_cnt;
            idx   <= next_idx;
            shift <= next_shift;
            busy  <= next_state != IDLE;
        end

    always_comb begin
        next_state = state;
        next_cnt   = cnt + 1'b1;
        next_idx   = idx;
        next_shift = shift;
        case (state)
            IDLE: begin
                next_cnt = '0;
                if (!rx_s) next_state = START;
            end
            START:
                if (half_end) begin
                    next_cnt   = '0;
                    next_idx   = '0;
                    next_state = rx_s ? IDLE : DATA;
                end
            DATA:
                if (bit_end) begin
                    next_cnt   = '0;
                    next_idx   = idx + 1'b1;
                    next_shift = {rx_s, shift[7:1]};
                    if (idx == 3'd7) next_state = STOP;
                end
            STOP:
                if (bit_end) begin
                    next_cnt   = '0;
                    next_state = rx_s ? IDLE : WAIT_IDLE;
                end
            WAIT_IDLE: begin
                next_cnt = '0;
                if (rx_s) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        done     = state == STOP && bit_end && rx_s;
        bad_stop = state == STOP && bit_end && !rx_s;
        load     = done && (!rx_valid || rx_ready);
    end

    // A consume in the completion cycle frees the register, so that byte is not an overrun
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            rx_byte     <= load ? shift : rx_byte;
            rx_valid    <= load || (rx_valid && !rx_ready);
            frame_error <= bad_stop;
            overrun     <= done && !load;
        end
endmodule
